// File: rtl/sserial_arb_pkg.sv
// sserial_pkg: types and constants shared by the serial sender arbiter and the sender
package sserial_pkg;
  typedef enum logic {IDLE, XFER} state_t;
  localparam int BYTE_W = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/sserial_arb_rr_pick.sv
// rr_pick: round-robin picker, first request strictly above ptr with wrap
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            any
);
  logic [NREQ-1:0] rot, first;
  always_comb begin
    rot = NREQ'({req, req} >> (int'(ptr) + 1));
    first = rot & -rot;
    win = NREQ'(({first, first} << (int'(ptr) + 1)) >> NREQ);
    any = |req;
  end
endmodule

// File: rtl/sserial_arb.sv
// sserial_arb: packet-level round-robin arbiter in front of a serial sender write port,
// holding each grant for a whole message and reclaiming it from stalled owners.
module sserial_arb
  import sserial_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic                   wr_clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        grant,
  output logic [BYTE_W-1:0]      ser_data,
  output logic                   ser_wr,
  input  logic                   ser_busy,
  output logic                   timeout_pulse
);
  localparam int PW = $clog2(NREQ);
  state_t state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d, win;
  logic [PW-1:0] ptr_q, ptr_d, own_idx;
  logic [TW-1:0] wd_q, wd_d;
  logic [BYTE_W-1:0] ser_data_q, ser_data_d, own_data;
  logic ser_wr_q, ser_wr_d, to_q, to_d, any, own_valid, own_last, accept, idle_cyc, fire;

  rr_pick #(.NREQ(NREQ)) u_pick (.req(req_valid), .ptr(ptr_q), .win(win), .any(any));

  always_comb begin
    own_valid = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    own_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        own_valid = req_valid[i];
        own_last = req_last[i];
        own_data = req_data[BYTE_W*i +: BYTE_W];
        own_idx = PW'(i);
      end
    end
    accept = state_q == XFER && own_valid && !ser_busy;
    // busy cycles are the sender's stall, not the owner's, so they do not age the watchdog
    idle_cyc = state_q == XFER && !own_valid && !ser_busy;
    fire = TIMEOUT != 0 && idle_cyc && wd_q == TW'(TIMEOUT - 1);
    req_ready = accept ? grant_q : '0;
    ser_wr_d = accept;
    ser_data_d = accept ? own_data : ser_data_q;
    to_d = fire;
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    wd_d = wd_q;
    if (state_q == IDLE && any) begin
      state_d = XFER;
      grant_d = win;
      wd_d = '0;
    end else if ((accept && own_last) || fire) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d = own_idx;
      wd_d = '0;
    end else if (accept) begin
      wd_d = '0;
    end else if (idle_cyc) begin
      wd_d = wd_q + TW'(1);
    end
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= PW'(NREQ - 1);
      wd_q <= '0;
      ser_data_q <= '0;
      ser_wr_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      wd_q <= wd_d;
      ser_data_q <= ser_data_d;
      ser_wr_q <= ser_wr_d;
      to_q <= to_d;
    end
  end

  assign grant = grant_q;
  assign ser_data = ser_data_q;
  assign ser_wr = ser_wr_q;
  assign timeout_pulse = to_q;
endmodule
